// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional two's-complement input yields sign + magnitude; overflow keeps the low NDIGIT digits.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NDIGIT = 5,
  parameter int unsigned SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      din,
  output logic                  busy,
  output logic                  valid,
  output logic [NDIGIT*4-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned W   = WIDTH + SIGNED;
  localparam int unsigned BW  = NDIGIT * 4;
  localparam int unsigned CW  = $clog2(W + 1);
  localparam int unsigned Pad = 1 - SIGNED;
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH:0]  mag_q, mag_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            oflow_q, oflow_d;
  logic            valid_q, valid_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH:0]  din_ext, mag_full;
  logic [BW-1:0]   acc_adj;

  // Magnitude is formed in WIDTH+1 bits and left-aligned so the first bit shifted is mag_q[WIDTH].
  always_comb begin
    din_ext  = (SIGNED != 0) ? {din[WIDTH-1], din} : {1'b0, din};
    mag_full = din_ext[WIDTH] ? -din_ext : din_ext;
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(NDIGIT); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    oflow_d = oflow_q;
    valid_d = 1'b0;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          mag_d   = mag_full << Pad;
          sign_d  = din_ext[WIDTH];
          acc_d   = '0;
          oflow_d = 1'b0;
          cnt_d   = '0;
        end
      end
      StShift: begin
        acc_d   = {acc_adj[BW-2:0], mag_q[WIDTH]};
        mag_d   = {mag_q[WIDTH-1:0], 1'b0};
        oflow_d = oflow_q | acc_adj[BW-1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: begin
        bcd_d   = acc_q;
        neg_d   = sign_q;
        ovf_d   = oflow_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      oflow_q <= 1'b0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      oflow_q <= oflow_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q != StIdle);
  assign valid = valid_q;
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: several parameter corners share one stimulus stream and are
// checked against a decimal model (digits via %10, sign via two's-complement arithmetic).
module tb_bin2bcd_seq;

  localparam int NI = 10;
  localparam int unsigned WS [NI] = '{16, 16, 16, 2, 2, 32, 32, 32, 2, 32};
  localparam int unsigned ND [NI] = '{5, 4, 5, 1, 1, 10, 10, 1, 10, 1};
  localparam int unsigned SG [NI] = '{0, 0, 1, 0, 1, 0, 1, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] din32 = '0;

  logic        busy_w  [NI];
  logic        valid_w [NI];
  logic        neg_w   [NI];
  logic        ovf_w   [NI];
  logic [39:0] bcd_w   [NI];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned GW  = WS[g];
    localparam int unsigned GND = ND[g];
    localparam int unsigned GS  = SG[g];
    logic [GND*4-1:0] b;
    bin2bcd_seq #(.WIDTH(GW), .NDIGIT(GND), .SIGNED(GS)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .din   (din32[GW-1:0]),
      .busy  (busy_w[g]),
      .valid (valid_w[g]),
      .bcd   (b),
      .neg   (neg_w[g]),
      .ovf   (ovf_w[g])
    );
    assign bcd_w[g] = 40'(b);
  end

  task automatic chk(input string tag, input int idx, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  function automatic void model(input int i, input logic [31:0] d, output logic [39:0] eb,
                                output logic en, output logic eo);
    longint unsigned v, mag, full;
    full = 64'd1 << WS[i];
    v    = 64'(d) & (full - 1);
    en   = (SG[i] != 0) && (v >= (full >> 1));
    mag  = en ? full - v : v;
    eb   = '0;
    for (int k = 0; k < int'(ND[i]); k++) begin
      eb  = eb | (40'(mag % 10) << (4 * k));
      mag = mag / 10;
    end
    eo = (mag != 0);
  endfunction

  // One conversion on every instance; restart_k > 0 pulses start again before edge restart_k.
  task automatic conv(input logic [31:0] d, input int restart_k);
    int lat [NI];
    int nval [NI];
    int nbusy [NI];
    logic [39:0] eb;
    logic en, eo;
    int w;
    for (int i = 0; i < NI; i++) begin
      lat[i] = -1; nval[i] = 0; nbusy[i] = 0;
    end
    din32 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    din32 = $urandom;
    for (int i = 0; i < NI; i++) if (busy_w[i]) nbusy[i]++;
    for (int k = 1; k <= 36; k++) begin
      if (k == restart_k) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      din32 = $urandom;
      for (int i = 0; i < NI; i++) begin
        if (valid_w[i]) begin nval[i]++; lat[i] = k; end
        if (busy_w[i]) nbusy[i]++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      w = int'(WS[i] + SG[i]);
      if (restart_k == 0 || w + 2 > restart_k) begin
        model(i, d, eb, en, eo);
        chk("latency", i, 64'(lat[i]), 64'(w + 1));
        chk("valid_count", i, 64'(nval[i]), 64'd1);
        chk("busy_cycles", i, 64'(nbusy[i]), 64'(w + 1));
        chk("bcd", i, 64'(bcd_w[i]), 64'(eb));
        chk("neg", i, 64'(neg_w[i]), 64'(en));
        chk("ovf", i, 64'(ovf_w[i]), 64'(eo));
      end
    end
  endtask

  initial begin
    logic [31:0] corners [6];
    logic [31:0] d;
    int cyc;
    bit seen;

    // Reset state, with start held high to show it is ignored under reset.
    rst = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy", i, 64'(busy_w[i]), 64'd0);
      chk("rst_valid", i, 64'(valid_w[i]), 64'd0);
      chk("rst_bcd", i, 64'(bcd_w[i]), 64'd0);
      chk("rst_neg", i, 64'(neg_w[i]), 64'd0);
      chk("rst_ovf", i, 64'(ovf_w[i]), 64'd0);
    end
    start = 1'b0;
    rst = 1'b1;

    conv(32'h0000_FFFF, 0);
    chk("ffff_bcd", 0, 64'(bcd_w[0]), 64'h65535);
    chk("ffff_ovf", 0, 64'(ovf_w[0]), 64'd0);
    chk("s_ffff_bcd", 2, 64'(bcd_w[2]), 64'h00001);
    chk("s_ffff_neg", 2, 64'(neg_w[2]), 64'd1);

    conv(32'd12345, 0);
    chk("nd4_12345_bcd", 1, 64'(bcd_w[1]), 64'h2345);
    chk("nd4_12345_ovf", 1, 64'(ovf_w[1]), 64'd1);
    conv(32'd9999, 0);
    chk("nd4_9999_bcd", 1, 64'(bcd_w[1]), 64'h9999);
    chk("nd4_9999_ovf", 1, 64'(ovf_w[1]), 64'd0);

    conv(32'h0000_8000, 0);
    chk("s_8000_bcd", 2, 64'(bcd_w[2]), 64'h32768);
    chk("s_8000_neg", 2, 64'(neg_w[2]), 64'd1);

    conv(32'd0, 0);

    // Start pulsed again mid-SHIFT with another operand must be ignored.
    conv(32'd1234, 5);
    chk("restart_bcd", 0, 64'(bcd_w[0]), 64'h01234);

    // Start in the cycle valid is high must be accepted.
    din32 = 32'd1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_w[0]) seen = 1'b1;
    end
    chk("valid_seen_a", 0, 64'(seen), 64'd1);
    din32 = 32'd777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_in_valid", 0, 64'(busy_w[0]), 64'd1);
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_w[0]) seen = 1'b1;
    end
    chk("valid_seen_b", 0, 64'(seen), 64'd1);
    chk("accept_bcd", 0, 64'(bcd_w[0]), 64'h00777);
    repeat (40) @(posedge clk);
    #1;

    // Reset in the middle of SHIFT abandons the conversion.
    din32 = 32'd5555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b1;
    seen = 1'b0;
    @(posedge clk); #1;
    if (valid_w[0]) seen = 1'b1;
    chk("midrst_busy", 0, 64'(busy_w[0]), 64'd0);
    chk("midrst_bcd", 0, 64'(bcd_w[0]), 64'd0);
    @(posedge clk); #1;
    if (valid_w[0]) seen = 1'b1;
    chk("midrst_busy2", 0, 64'(busy_w[0]), 64'd0);
    chk("midrst_novalid", 0, 64'(seen), 64'd0);
    start = 1'b0;
    rst = 1'b1;
    conv(32'd42, 0);
    chk("after_rst_bcd", 0, 64'(bcd_w[0]), 64'h00042);

    corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h2};
    foreach (corners[j]) conv(corners[j], 0);

    for (int n = 0; n < 40; n++) begin
      d = $urandom;
      case (n % 4)
        0: d = d;
        1: d = d & 32'h0000_FFFF;
        2: d = d & 32'h0000_000F;
        default: d = d | 32'h8000_0000;
      endcase
      conv(d, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
